// File: rtl/convex_pkg.sv
// Shared widths, point type and transmitter state encoding for the CONVEX point source.
package convex_pkg;

   localparam int COORD_W = 10;
   localparam int NUM_W   = 9;
   localparam int DEPTH   = 2 ** NUM_W;
   localparam int CNT_W   = NUM_W + 1;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_OUT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/convex_pt_tx_if.sv
// CONVEX point-stream link: the transmitter is master, the CONVEX core is slave.
interface convex_pt_tx_if;
   import convex_pkg::*;

   logic               in_valid;
   logic [NUM_W-1:0]   pt_num;
   logic [COORD_W-1:0] in_x;
   logic [COORD_W-1:0] in_y;
   logic               out_valid;

   modport master (
      output in_valid,
      output pt_num,
      output in_x,
      output in_y,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  pt_num,
      input  in_x,
      input  in_y,
      output out_valid
   );

endinterface

// File: rtl/convex_pt_buf.sv
// Single-port point buffer with registered read address; stands in for an SRAM macro.
module convex_pt_buf
   import convex_pkg::*;
(
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [NUM_W-1:0] addr,
   input  point_t           wdata,
   output point_t           rdata
);

   point_t           mem [DEPTH];
   logic [NUM_W-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         addr_q <= addr;
      end
   end

   assign rdata = mem[addr_q];

endmodule

// File: rtl/convex_pt_tx.sv
// CONVEX point-stream transmitter: buffers host points, replays a batch, waits for the output burst.
// Optional WAIT_OUT timeout is built when CONVEX_TX_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | host loads points; start is checked against the load count
// SEND     | buffer replayed one point per cycle on in_valid
// WAIT_OUT | waiting for the CONVEX out_valid burst to rise and fall
module convex_pt_tx
   import convex_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_valid,
   input  logic [COORD_W-1:0] ld_x,
   input  logic [COORD_W-1:0] ld_y,
   output logic               ld_ready,
   input  logic               start,
   input  logic [NUM_W-1:0]   start_num,
   output logic               busy,
   output logic               done,
   output logic               err,
   convex_pt_tx_if.master     cvx
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_SEND = SEND;
   localparam logic [1:0] ST_WAIT = WAIT_OUT;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_upd;
   logic [NUM_W-1:0] n_q;
   logic [NUM_W-1:0] rd_ptr;
   logic [NUM_W-1:0] iss_left;
   logic             rd_vld_q;
   logic             rd_first_q;
   logic             rd_last_q;
   logic             out_last_q;
   logic             seen_hi;

   logic             load_fire;
   logic             start_ok;
   logic             issue;
   logic             buf_en;
   logic [NUM_W-1:0] buf_addr;
   point_t           wpt;
   point_t           rpt;

   always_comb begin
      load_fire = (state == ST_IDLE) && ld_valid && ld_ready;
      cnt_upd   = cnt + CNT_W'(load_fire);
      start_ok  = (start_num != '0) && ({1'b0, start_num} <= cnt_upd);
      issue     = (state == ST_SEND) && (iss_left != '0);
      buf_en    = load_fire || issue;
      buf_addr  = (state == ST_SEND) ? rd_ptr : cnt[NUM_W-1:0];
      wpt.x     = ld_x;
      wpt.y     = ld_y;
   end

   convex_pt_buf u_buf (
      .clk   (clk),
      .en    (buf_en),
      .we    (load_fire),
      .addr  (buf_addr),
      .wdata (wpt),
      .rdata (rpt)
   );

`ifdef CONVEX_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
   logic [TO_W-1:0] to_cnt;
`else
   logic unused_to;
   assign unused_to = (TIMEOUT_CYC == 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         n_q          <= '0;
         rd_ptr       <= '0;
         iss_left     <= '0;
         rd_vld_q     <= 1'b0;
         rd_first_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         out_last_q   <= 1'b0;
         seen_hi      <= 1'b0;
         ld_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         cvx.in_valid <= 1'b0;
         cvx.pt_num   <= '0;
         cvx.in_x     <= '0;
         cvx.in_y     <= '0;
`ifdef CONVEX_TX_TIMEOUT_EN
         to_cnt       <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         // Two-stage replay pipe: address issue, then RAM data into the output registers.
         rd_vld_q     <= issue;
         rd_first_q   <= issue && (rd_ptr == '0);
         rd_last_q    <= issue && (iss_left == NUM_W'(1));
         out_last_q   <= rd_last_q;
         cvx.in_valid <= rd_vld_q;
         cvx.pt_num   <= rd_first_q ? n_q : '0;
         cvx.in_x     <= rd_vld_q ? rpt.x : '0;
         cvx.in_y     <= rd_vld_q ? rpt.y : '0;

         if (issue) begin
            rd_ptr   <= rd_ptr + NUM_W'(1);
            iss_left <= iss_left - NUM_W'(1);
         end

         case (state)
            ST_IDLE: begin
               cnt <= cnt_upd;
               if (start && start_ok) begin
                  state    <= ST_SEND;
                  n_q      <= start_num;
                  rd_ptr   <= '0;
                  iss_left <= start_num;
                  ld_ready <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  err      <= start;
                  ld_ready <= (cnt_upd < CNT_W'(DEPTH));
               end
            end
            ST_SEND: begin
               if (cvx.in_valid && out_last_q) begin
                  state   <= ST_WAIT;
                  seen_hi <= 1'b0;
`ifdef CONVEX_TX_TIMEOUT_EN
                  to_cnt  <= TO_W'(TIMEOUT_CYC - 1);
`endif
               end
            end
            ST_WAIT: begin
               if (cvx.out_valid) begin
                  seen_hi <= 1'b1;
               end
               if (!cvx.out_valid && seen_hi) begin
                  done     <= 1'b1;
                  cnt      <= '0;
                  state    <= ST_IDLE;
                  ld_ready <= 1'b1;
                  busy     <= 1'b0;
               end
`ifdef CONVEX_TX_TIMEOUT_EN
               else if (to_cnt == '0) begin
                  err      <= 1'b1;
                  cnt      <= '0;
                  state    <= ST_IDLE;
                  ld_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  to_cnt <= to_cnt - TO_W'(1);
               end
`endif
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/convex_pt_tx.md
Name: convex_pt_tx

Overview:
- Point-stream transmitter. Drives the CONVEX input protocol (in_valid / pt_num / in_x / in_y) and watches the CONVEX out_valid to pace batches.
- A host loads up to DEPTH points into an internal buffer, then issues start. The block replays the points one per cycle and waits for the CONVEX output burst to finish before reporting done.
- It is the source end of the CONVEX interface. Used by the bench and by the system-level wrapper.

Parameters:
- COORD_W, 10, coordinate width of x and y.
- NUM_W, 9, width of pt_num and start_num.
- DEPTH, 512, point-buffer entries; must be 2**NUM_W.
- TIMEOUT_CYC, 1000, cycles allowed in WAIT_OUT (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  host point-load strobe.
- ld_x  in  COORD_W  x coordinate to load.
- ld_y  in  COORD_W  y coordinate to load.
- ld_ready  out  1  buffer accepts a load this cycle.
- start  in  1  begin a batch; sampled in IDLE only.
- start_num  in  NUM_W  number of points to send.
- busy  out  1  high in SEND and WAIT_OUT.
- done  out  1  one-cycle pulse when a batch completes.
- err  out  1  one-cycle pulse when start is rejected.
- in_valid  out  1  to CONVEX.
- pt_num  out  NUM_W  to CONVEX.
- in_x  out  COORD_W  to CONVEX.
- in_y  out  COORD_W  to CONVEX.
- out_valid  in  1  from CONVEX.

Behaviour:
- Reset values: every output is 0. State = IDLE, load count = 0, read pointer = 0. A reset asserted in any state aborts the batch; in_valid drops the cycle after rst is sampled.
- Clocking: all outputs are registered.
- States and transitions:
  - IDLE: ld_ready = (cnt < DEPTH). A cycle with ld_valid && ld_ready writes buf[cnt] and increments cnt.
    - start with start_num == 0, or start_num > cnt: err pulses next cycle, state stays IDLE.
    - Otherwise: latch N = start_num, set rd_ptr = 0, go to SEND.
    - start and ld_valid in the same cycle: the load is applied first, and the start check uses the updated cnt.
  - SEND: ld_ready = 0. in_valid is high for exactly N consecutive cycles, no gaps.
    - Cycle k (0..N-1) carries in_x/in_y = buf[k].
    - pt_num = N on cycle 0 only, 0 on all other cycles.
    - After cycle N-1: in_valid, in_x, in_y and pt_num all return to 0, and the state moves to WAIT_OUT.
    - out_valid seen during SEND is a protocol violation: ignore it for sequencing; it is flagged by bench assertions only.
  - WAIT_OUT: first wait for out_valid to go high, then wait for its falling edge. The cycle after out_valid is sampled low following at least one high cycle: done pulses, cnt clears to 0, state goes to IDLE.
- Buffer: a single-port array, DEPTH x 2*COORD_W. The read address is registered, so buffer read latency is 1 cycle. The read is issued one cycle ahead so that in_valid has no bubble.
- Boundaries:
  - cnt == DEPTH: ld_ready = 0, and ld_valid is dropped silently.
  - N == DEPTH - 1 (511) is the maximum legal batch.
  - start while busy is ignored.

Optional Feature:
- CONVEX_TX_TIMEOUT_EN defined:
  - A counter runs in WAIT_OUT. If it reaches TIMEOUT_CYC without completion, err pulses, cnt clears, and the state goes to IDLE. done does not pulse.
  - The counter is cleared on entering WAIT_OUT.
- Undefined: WAIT_OUT waits indefinitely, no counter logic is generated, and TIMEOUT_CYC is unused.

Decomposition:
- Package convex_pkg:
  - COORD_W, NUM_W, DEPTH constants.
  - A point typedef, a struct {x, y}.
  - An enum for tx_state_t {IDLE, SEND, WAIT_OUT}.
- One sub-module: convex_pt_buf, the single-port synchronous RAM wrapper with registered read. It is replaced by an SRAM macro at synthesis.

Test Plan:
- Load 3 points (1,2), (3,4), (5,6), start_num = 3:
  - in_valid high 3 cycles carrying (1,2), (3,4), (5,6).
  - pt_num = 3 on the first cycle, then 0.
  - CONVEX out_valid high 2 cycles then low: done pulses once, busy = 0.
- Load 2 points, start_num = 5: err pulses the next cycle, in_valid stays 0, and the 2 loaded points are retained.
- Load 511 points with x = y = index, start_num = 511:
  - 511 contiguous in_valid cycles and the final point is (510,510).
  - A 512th load is accepted; with cnt = 512, ld_ready = 0 and a 513th ld_valid is dropped.
- Assert rst on cycle 4 of a 10-point SEND: in_valid = 0 the next cycle, all outputs are 0, cnt = 0, and no done pulse.
- With CONVEX_TX_TIMEOUT_EN and TIMEOUT_CYC = 20, hold out_valid = 0 after SEND: err pulses 20 cycles after entering WAIT_OUT, and the block returns to IDLE.
- Start pulsed during SEND and WAIT_OUT: ignored, the batch completes normally with one done pulse.
